// File: rtl/peak_pkg.sv
// Shared types and constants for the FFT peak-scan path: frame size,
// sequencer states and the real/imag field positions inside a packed bin.
package peak_pkg;

  localparam int DEF_NBINS = 16;
  localparam int DEF_FW    = 4;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SCAN = 2'd1,
    CAPT = 2'd2
  } state_t;

  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  // Squared magnitude of a packed bin; worst case (-32768)^2 * 2 needs 33 bits.
  function automatic logic [32:0] bin_mag2(input logic [31:0] bin);
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic signed [33:0] acc;
    re  = bin[RE_MSB:RE_LSB];
    im  = bin[IM_MSB:IM_LSB];
    acc = 34'(re * re) + 34'(im * im);
    return acc[32:0];
  endfunction

endpackage

// File: rtl/peak_bin_buf.sv
// One-frame bin store: a single synchronous write port, a combinational read
// port at any address, and a dedicated combinational tap on entry 0.
module peak_bin_buf #(
  parameter int NBINS = peak_pkg::DEF_NBINS,
  parameter int FW    = peak_pkg::DEF_FW
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [FW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [FW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic [31:0]   rd0_data
);

  logic [31:0] mem [NBINS];

  // NOTE: the storage array has no reset; every entry is written during FILL
  // before SCAN reads it, so a reset would only cost flop area and fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign rd0_data = mem[0];

endmodule

// File: rtl/peak_scan_ctrl.sv
// Frame sequencer ahead of the magnitude comparator: buffers NBINS bins, walks
// them through the comparator against its running winner, then latches the peak.
module peak_scan_ctrl #(
  parameter int NBINS = peak_pkg::DEF_NBINS,
  parameter int FW    = peak_pkg::DEF_FW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  output logic          in_ready,
  output logic          cmp_en,
  output logic [31:0]   cmp_data1,
  output logic [31:0]   cmp_data2,
  output logic [FW-1:0] cmp_freq1,
  output logic [FW-1:0] cmp_freq2,
  input  logic [31:0]   cmp_win_data,
  input  logic [FW-1:0] cmp_win_freq,
  output logic [31:0]   peak_data,
  output logic [FW-1:0] peak_freq,
  output logic          done
);

  import peak_pkg::*;

  localparam logic [FW:0]   LAST_WCNT = (FW+1)'(NBINS - 1);
  localparam logic [FW-1:0] LAST_K    = FW'(NBINS - 1);
  localparam logic [FW-1:0] FIRST_K   = FW'(1);

  state_t        state;
  logic [FW:0]   wcnt;
  logic [FW-1:0] k;
  logic          wr_en;
  logic [31:0]   bin_k;
  logic [31:0]   bin_0;

  assign in_ready = (state == FILL);
  assign cmp_en   = (state == SCAN);
  assign wr_en    = in_ready && in_valid;

  peak_bin_buf #(
    .NBINS (NBINS),
    .FW    (FW)
  ) u_bin_buf (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wcnt[FW-1:0]),
    .wr_data  (in_data),
    .rd_addr  (k),
    .rd_data  (bin_k),
    .rd0_data (bin_0)
  );

  // NOTE: every output of this block gets a default first so no path through
  // the conditionals leaves a value unassigned and infers a latch.
  always_comb begin
    cmp_data1 = '0;
    cmp_freq1 = '0;
    cmp_data2 = '0;
    cmp_freq2 = '0;
    if (state == SCAN) begin
      cmp_data2 = bin_k;
      cmp_freq2 = k;
      if (k != FIRST_K) begin
        cmp_data1 = cmp_win_data;
        cmp_freq1 = cmp_win_freq;
      end else begin
        cmp_data1 = bin_0;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      wcnt      <= '0;
      k         <= '0;
      peak_data <= '0;
      peak_freq <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FILL: begin
          if (in_valid) begin
            if (wcnt == LAST_WCNT) begin
              state <= SCAN;
              wcnt  <= '0;
              // Index 0 is consumed as the seed operand, so the scan starts at 1.
              k     <= FIRST_K;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        SCAN: begin
          if (k == LAST_K) begin
            state <= CAPT;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        CAPT: begin
          peak_data <= cmp_win_data;
          peak_freq <= cmp_win_freq;
          done      <= 1'b1;
          wcnt      <= '0;
          state     <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Directed bench for peak_scan_ctrl with a behavioural comparator model and a
// scoreboard of expected peaks popped on each done pulse.
module tb_peak_scan_ctrl;

  localparam int NB  = 16;
  localparam int FWB = 4;

  typedef logic [31:0] frame_t [NB];

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic [31:0]    in_data = '0;
  logic           in_ready;
  logic           cmp_en;
  logic [31:0]    cmp_data1, cmp_data2;
  logic [FWB-1:0] cmp_freq1, cmp_freq2;
  logic [31:0]    cw_data;
  logic [FWB-1:0] cw_freq;
  logic [31:0]    peak_data;
  logic [FWB-1:0] peak_freq;
  logic           done;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_done_cyc = 0;
  logic [35:0] sb_q [$];

  peak_scan_ctrl #(.NBINS(NB), .FW(FWB)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cmp_en       (cmp_en),
    .cmp_data1    (cmp_data1),
    .cmp_data2    (cmp_data2),
    .cmp_freq1    (cmp_freq1),
    .cmp_freq2    (cmp_freq2),
    .cmp_win_data (cw_data),
    .cmp_win_freq (cw_freq),
    .peak_data    (peak_data),
    .peak_freq    (peak_freq),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint mag(input logic [31:0] d);
    logic signed [15:0] re;
    logic signed [15:0] im;
    re = d[31:16];
    im = d[15:0];
    return longint'(re) * longint'(re) + longint'(im) * longint'(im);
  endfunction

  // Comparator model: registered winner, data1 kept on a tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cw_data <= '0;
      cw_freq <= '0;
    end else if (cmp_en) begin
      if (mag(cmp_data2) > mag(cmp_data1)) begin
        cw_data <= cmp_data2;
        cw_freq <= cmp_freq2;
      end else begin
        cw_data <= cmp_data1;
        cw_freq <= cmp_freq1;
      end
    end
  end

  function automatic logic [35:0] expected_peak(input frame_t b);
    int best = 0;
    for (int i = 1; i < NB; i++) begin
      if (mag(b[i]) > mag(b[best])) best = i;
    end
    return {4'(best), b[best]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_done(input bit junk);
    int n = 1;
    logic [35:0] e;
    while (done !== 1'b1 && n < 40) begin
      check("in_ready_busy", in_ready, 1'b0);
      if (junk) begin
        in_valid = 1'b1;
        in_data  = {16'h7FFF - 16'(n), 16'h7FF0};
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("done_seen", done, 1'b1);
    if (done !== 1'b1) return;
    check("done_latency", 64'(n), 64'd17);
    check("in_ready_done", in_ready, 1'b1);
    check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("peak_freq", peak_freq, e[35:32]);
      check("peak_data", peak_data, e[31:0]);
    end
    last_done_cyc = cyc;
  endtask

  // Starts driving at the current negedge so a frame can follow a done pulse directly.
  task automatic send_frame(input frame_t b, input bit junk);
    sb_q.push_back(expected_peak(b));
    for (int i = 0; i < NB; i++) begin
      in_valid = 1'b1;
      in_data  = b[i];
      check("in_ready_fill", in_ready, 1'b1);
      check("cmp_en_fill", cmp_en, 1'b0);
      if (i == 1) check("done_one_cycle", done, 1'b0);
      @(negedge clk);
    end
    wait_done(junk);
  endtask

  initial begin
    frame_t f;
    int d4;

    #2;
    check("rst_peak_data", peak_data, 32'h0);
    check("rst_peak_freq", peak_freq, 4'h0);
    check("rst_done", done, 1'b0);
    check("rst_cmp_en", cmp_en, 1'b0);
    check("rst_cmp_data1", cmp_data1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1'b1);

    // Magnitude ramp
    for (int i = 0; i < NB; i++) f[i] = {16'(i), 16'h0};
    send_frame(f, 1'b0);
    check("ramp_freq", peak_freq, 4'd15);
    check("ramp_data", peak_data, 32'h000F_0000);

    // Negative extreme beats the largest positive value
    for (int i = 0; i < NB; i++) f[i] = 32'h0;
    f[5] = 32'h8000_0000;
    f[9] = 32'h7FFF_0000;
    send_frame(f, 1'b0);
    check("neg_freq", peak_freq, 4'd5);

    // Tie goes to the lower index; junk offered while busy must be dropped
    for (int i = 0; i < NB; i++) f[i] = 32'h0;
    f[3]  = 32'h0010_0010;
    f[12] = 32'h0010_0010;
    send_frame(f, 1'b1);
    check("tie_freq", peak_freq, 4'd3);

    // Back-to-back frames, the first starting in the tie frame's done cycle
    for (int i = 0; i < NB; i++) f[i] = {16'(i), 16'(i)};
    f[10] = 32'h0100_FF00;
    send_frame(f, 1'b0);
    check("b2b_first_freq", peak_freq, 4'd10);
    d4 = last_done_cyc;
    for (int i = 0; i < NB; i++) f[i] = 32'h0010_0020;
    f[1] = 32'hF000_0000;
    send_frame(f, 1'b0);
    check("b2b_second_freq", peak_freq, 4'd1);
    check("b2b_period", 64'(last_done_cyc - d4), 64'd32);

    // Reset mid-fill discards the partial frame
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h4000_4000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_peak_data", peak_data, 32'h0);
    check("midrst_peak_freq", peak_freq, 4'h0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NB; i++) f[i] = {16'(i), 16'(i)};
    f[2] = 32'h0300_0000;
    send_frame(f, 1'b0);
    check("midrst_frame_freq", peak_freq, 4'd2);
    check("midrst_frame_data", peak_data, 32'h0300_0000);

    @(negedge clk);
    check("done_dropped", done, 1'b0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
